// File: rtl/spi_transfer_queue.sv
// Byte queue in front of an SPI shift engine: TX FIFO feeds the engine back-to-back,
// received bytes land in an RX FIFO. One transfer in flight at a time.
module spi_transfer_queue #(
    parameter  int DEPTH    = 4,
    localparam int PTR_BITS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                flush,
    input  logic                discardRx,
    input  logic                tx_valid,
    input  logic [7:0]          tx_data,
    output logic                tx_ready,
    output logic                rx_valid,
    output logic [7:0]          rx_data,
    input  logic                rx_ready,
    output logic [PTR_BITS:0]   tx_count,
    output logic [PTR_BITS:0]   rx_count,
    output logic                active,
    output logic                engine_load,
    output logic [7:0]          engine_data,
    input  logic                engine_busy,
    input  logic [7:0]          engine_rxData
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_CAPTURE   = 3'd4
    } state_t;

    localparam logic [PTR_BITS:0] PTR_ZERO = {(PTR_BITS+1){1'b0}};
    localparam logic [PTR_BITS:0] PTR_ONE  = {{PTR_BITS{1'b0}}, 1'b1};

    state_t             r_state;
    logic               r_engine_load;
    logic [7:0]         r_engine_data;
    logic               r_flush_pend;
    logic [PTR_BITS:0]  r_tx_wr;
    logic [PTR_BITS:0]  r_tx_rd;
    logic [PTR_BITS:0]  r_rx_wr;
    logic [PTR_BITS:0]  r_rx_rd;
    logic [7:0]         r_tx_mem [DEPTH];
    logic [7:0]         r_rx_mem [DEPTH];

    logic               w_tx_full;
    logic               w_tx_empty;
    logic               w_rx_full;
    logic               w_rx_empty;
    logic               w_tx_push;
    logic               w_tx_pop;
    logic               w_rx_push;
    logic               w_rx_pop;
    logic               w_launch;
    logic [7:0]         w_tx_head;

    assign w_tx_full  = (r_tx_wr[PTR_BITS] != r_tx_rd[PTR_BITS]) &&
                        (r_tx_wr[PTR_BITS-1:0] == r_tx_rd[PTR_BITS-1:0]);
    assign w_tx_empty = (r_tx_wr == r_tx_rd);
    assign w_rx_full  = (r_rx_wr[PTR_BITS] != r_rx_rd[PTR_BITS]) &&
                        (r_rx_wr[PTR_BITS-1:0] == r_rx_rd[PTR_BITS-1:0]);
    assign w_rx_empty = (r_rx_wr == r_rx_rd);
    assign w_tx_head  = r_tx_mem[r_tx_rd[PTR_BITS-1:0]];

    // A full TX FIFO rejects pushes even when the FSM pops in the same cycle.
    assign w_tx_push = tx_valid && !w_tx_full;
    assign w_tx_pop  = (r_state == ST_LOAD) && !w_tx_empty;
    assign w_rx_pop  = rx_ready && !w_rx_empty;
    assign w_rx_push = (r_state == ST_CAPTURE) && !discardRx && !r_flush_pend &&
                       (!w_rx_full || w_rx_pop);
    // RX space is reserved before launch so a capture can never overflow.
    assign w_launch  = enable && !w_tx_empty && (discardRx || !w_rx_full) && !flush;

    assign tx_ready    = !w_tx_full;
    assign rx_valid    = !w_rx_empty;
    assign rx_data     = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd[PTR_BITS-1:0]];
    assign tx_count    = r_tx_wr - r_tx_rd;
    assign rx_count    = r_rx_wr - r_rx_rd;
    assign active      = (r_state != ST_IDLE) || !w_tx_empty;
    assign engine_load = r_engine_load;
    assign engine_data = r_engine_data;

    // FIFO pointer update; flush overrides any push or pop in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wr <= PTR_ZERO;
            r_tx_rd <= PTR_ZERO;
            r_rx_wr <= PTR_ZERO;
            r_rx_rd <= PTR_ZERO;
        end else if (flush) begin
            r_tx_wr <= PTR_ZERO;
            r_tx_rd <= PTR_ZERO;
            r_rx_wr <= PTR_ZERO;
            r_rx_rd <= PTR_ZERO;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + PTR_ONE;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + PTR_ONE;
            if (w_rx_push) r_rx_wr <= r_rx_wr + PTR_ONE;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + PTR_ONE;
        end
    end

    // FIFO storage writes
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_tx_push) r_tx_mem[r_tx_wr[PTR_BITS-1:0]] <= tx_data;
        if (!rst && !flush && w_rx_push) r_rx_mem[r_rx_wr[PTR_BITS-1:0]] <= engine_rxData;
    end

    // Transfer sequencer with registered engine handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_engine_load <= 1'b0;
            r_engine_data <= 8'h00;
            r_flush_pend  <= 1'b0;
        end else begin
            r_engine_load <= 1'b0;
            if (r_state == ST_CAPTURE) begin
                r_flush_pend <= 1'b0;
            end else if (flush && (r_state != ST_IDLE)) begin
                r_flush_pend <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_state       <= ST_LOAD;
                        r_engine_load <= 1'b1;
                        r_engine_data <= w_tx_head;
                    end
                end
                ST_LOAD:      r_state <= ST_WAIT_BUSY;
                ST_WAIT_BUSY: if (engine_busy)  r_state <= ST_WAIT_DONE;
                ST_WAIT_DONE: if (!engine_busy) r_state <= ST_CAPTURE;
                ST_CAPTURE:   r_state <= ST_IDLE;
                default:      r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_transfer_queue.sv
// Bench for spi_transfer_queue: loopback engine model, directed scenarios and a
// randomized run checked against queue-based expectations.
module tb_spi_transfer_queue;

    logic       clk = 1'b0;
    logic       rst, enable, flush, discardRx, tx_valid, rx_ready;
    logic [7:0] tx_data;
    logic       tx_ready, rx_valid, active, engine_load, engine_busy;
    logic [7:0] rx_data, engine_data, engine_rxData;
    logic [2:0] tx_count, rx_count;

    int n_checks = 0;
    int n_errors = 0;
    int eng_len  = 3;
    logic [7:0] q_loads [$];

    logic [2:0] eng_cnt;
    logic [7:0] eng_shift;

    spi_transfer_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush), .discardRx(discardRx),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_count(tx_count), .rx_count(rx_count), .active(active),
        .engine_load(engine_load), .engine_data(engine_data),
        .engine_busy(engine_busy), .engine_rxData(engine_rxData)
    );

    always #5 clk = ~clk;

    // Loopback shift engine: busy the cycle after load for eng_len cycles, MISO = MOSI
    always @(posedge clk) begin
        if (rst) begin
            engine_busy   <= 1'b0;
            eng_cnt       <= 3'd0;
            engine_rxData <= 8'h00;
        end else if (engine_load) begin
            engine_busy <= 1'b1;
            eng_cnt     <= eng_len[2:0];
            eng_shift   <= engine_data;
            q_loads.push_back(engine_data);
        end else if (engine_busy) begin
            if (eng_cnt <= 3'd1) begin
                engine_busy   <= 1'b0;
                engine_rxData <= eng_shift;
            end else begin
                eng_cnt <= eng_cnt - 3'd1;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        tx_valid = 1'b1; tx_data = b;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pop_expect(input logic [7:0] exp);
        n_checks++;
        if (rx_data !== exp || rx_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL pop: rx_data=%0h rx_valid=%0b expected %0h valid", rx_data, rx_valid, exp);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (!active) break;
            @(negedge clk);
        end
        n_checks++;
        if (active) begin
            n_errors++;
            $display("FAIL wait_idle: active still 1 after %0d cycles, expected 0", budget);
        end
    endtask

    task automatic wait_busy(input logic lvl, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (engine_busy == lvl) break;
            @(negedge clk);
        end
        n_checks++;
        if (engine_busy !== lvl) begin
            n_errors++;
            $display("FAIL wait_busy: engine_busy=%0b, expected %0b", engine_busy, lvl);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if ({tx_ready, rx_valid, tx_count, rx_count, active, engine_load, engine_data, rx_data} !==
            {1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
            n_errors++;
            $display("FAIL %s: rdy=%0b rxv=%0b txc=%0d rxc=%0d act=%0b ld=%0b ed=%0h rd=%0h expected reset values",
                     tag, tx_ready, rx_valid, tx_count, rx_count, active, engine_load, engine_data, rx_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_reset");
    endtask

    task automatic test_single();
        int i;
        discardRx = 1'b0; enable = 1'b1; eng_len = 3; q_loads.delete();
        push_byte(8'hA5);
        n_checks++;
        if (engine_load !== 1'b0 || tx_count !== 3'd1) begin
            n_errors++; $display("FAIL single_queued: ld=%0b txc=%0d expected 0 1", engine_load, tx_count);
        end
        @(negedge clk);
        n_checks++;
        if (engine_load !== 1'b1 || engine_data !== 8'hA5) begin
            n_errors++; $display("FAIL single_load: ld=%0b data=%0h expected 1 a5", engine_load, engine_data);
        end
        @(negedge clk);
        n_checks++;
        if (tx_count !== 3'd0 || engine_load !== 1'b0) begin
            n_errors++; $display("FAIL single_pop: txc=%0d ld=%0b expected 0 0", tx_count, engine_load);
        end
        wait_busy(1'b0, 20);
        n_checks++;
        if (rx_valid !== 1'b0) begin
            n_errors++; $display("FAIL single_early_rx: rx_valid=%0b expected 0", rx_valid);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hA5 || rx_count !== 3'd1) begin
            n_errors++; $display("FAIL single_rx: v=%0b d=%0h c=%0d expected 1 a5 1", rx_valid, rx_data, rx_count);
        end
        wait_idle(20);
        n_checks++;
        if (q_loads.size() != 1) begin
            n_errors++; $display("FAIL single_loads: %0d loads, expected 1", q_loads.size());
        end
        pop_expect(8'hA5);
        n_checks++;
        if (rx_count !== 3'd0 || rx_valid !== 1'b0) begin
            n_errors++; $display("FAIL single_drain: rxc=%0d v=%0b expected 0 0", rx_count, rx_valid);
        end
    endtask

    task automatic test_full();
        enable = 1'b0; eng_len = 2; q_loads.delete();
        for (int i = 1; i <= 4; i++) push_byte(8'(i));
        n_checks++;
        if (tx_ready !== 1'b0 || tx_count !== 3'd4) begin
            n_errors++; $display("FAIL full: rdy=%0b txc=%0d expected 0 4", tx_ready, tx_count);
        end
        push_byte(8'h05);
        n_checks++;
        if (tx_count !== 3'd4) begin
            n_errors++; $display("FAIL full_drop: txc=%0d expected 4", tx_count);
        end
        enable = 1'b1;
        wait_idle(100);
        n_checks++;
        if (q_loads.size() != 4) begin
            n_errors++; $display("FAIL full_loads: %0d loads, expected 4", q_loads.size());
        end
        for (int i = 0; i < 4 && i < q_loads.size(); i++) begin
            n_checks++;
            if (q_loads[i] !== 8'(i + 1)) begin
                n_errors++; $display("FAIL full_order: load %0d = %0h expected %0h", i, q_loads[i], i + 1);
            end
        end
        n_checks++;
        if (rx_count !== 3'd4) begin
            n_errors++; $display("FAIL full_rxc: %0d expected 4", rx_count);
        end
        for (int i = 1; i <= 4; i++) pop_expect(8'(i));
    endtask

    task automatic test_rx_full();
        logic [7:0] b [4];
        enable = 1'b1; discardRx = 1'b0; eng_len = $urandom_range(1, 4);
        for (int i = 0; i < 4; i++) begin
            b[i] = 8'($urandom);
            push_byte(b[i]);
        end
        wait_idle(100);
        n_checks++;
        if (rx_count !== 3'd4) begin
            n_errors++; $display("FAIL rxfull_cnt: %0d expected 4", rx_count);
        end
        q_loads.delete();
        push_byte(8'h55);
        repeat (15) @(negedge clk);
        n_checks++;
        if (q_loads.size() != 0 || tx_count !== 3'd1 || active !== 1'b1) begin
            n_errors++; $display("FAIL rxfull_hold: loads=%0d txc=%0d act=%0b expected 0 1 1",
                                 q_loads.size(), tx_count, active);
        end
        pop_expect(b[0]);
        wait_idle(50);
        n_checks++;
        if (q_loads.size() != 1 || q_loads[0] !== 8'h55) begin
            n_errors++; $display("FAIL rxfull_resume: loads=%0d expected one load of 55", q_loads.size());
        end
        for (int i = 1; i < 4; i++) pop_expect(b[i]);
        pop_expect(8'h55);
    endtask

    task automatic test_discard();
        logic [7:0] b [3];
        enable = 1'b1; discardRx = 1'b1; eng_len = 2; q_loads.delete();
        for (int i = 0; i < 3; i++) begin
            b[i] = 8'($urandom);
            push_byte(b[i]);
        end
        wait_idle(100);
        n_checks++;
        if (q_loads.size() != 3 || rx_count !== 3'd0) begin
            n_errors++; $display("FAIL discard: loads=%0d rxc=%0d expected 3 0", q_loads.size(), rx_count);
        end
        for (int i = 0; i < 3 && i < q_loads.size(); i++) begin
            n_checks++;
            if (q_loads[i] !== b[i]) begin
                n_errors++; $display("FAIL discard_order: load %0d = %0h expected %0h", i, q_loads[i], b[i]);
            end
        end
        discardRx = 1'b0;
    endtask

    task automatic test_flush();
        logic [7:0] b [3];
        enable = 1'b0; discardRx = 1'b0; eng_len = 6; q_loads.delete();
        for (int i = 0; i < 3; i++) begin
            b[i] = 8'($urandom);
            push_byte(b[i]);
        end
        enable = 1'b1;
        wait_busy(1'b1, 20);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (tx_count !== 3'd0 || tx_ready !== 1'b1) begin
            n_errors++; $display("FAIL flush_tx: txc=%0d rdy=%0b expected 0 1", tx_count, tx_ready);
        end
        wait_idle(50);
        repeat (10) @(negedge clk);
        n_checks++;
        if (q_loads.size() != 1 || q_loads[0] !== b[0] || rx_count !== 3'd0 || rx_valid !== 1'b0) begin
            n_errors++; $display("FAIL flush_rx: loads=%0d rxc=%0d rxv=%0b expected 1 0 0",
                                 q_loads.size(), rx_count, rx_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] c [3];
        enable = 1'b1; discardRx = 1'b0; eng_len = 6;
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        wait_busy(1'b1, 20);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_mid");
        rst = 1'b0;
        eng_len = 2;
        for (int i = 0; i < 3; i++) c[i] = 8'($urandom);
        push_byte(c[0]);
        push_byte(c[1]);
        wait_idle(60);
        n_checks++;
        if (rx_count !== 3'd2) begin
            n_errors++; $display("FAIL b2b_fill: rxc=%0d expected 2", rx_count);
        end
        push_byte(c[2]);
        wait_busy(1'b1, 20);
        wait_busy(1'b0, 20);
        @(negedge clk);
        n_checks++;
        if (rx_data !== c[0]) begin
            n_errors++; $display("FAIL b2b_head: rx_data=%0h expected %0h", rx_data, c[0]);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        n_checks++;
        if (rx_count !== 3'd2 || rx_data !== c[1]) begin
            n_errors++; $display("FAIL b2b_pushpop: rxc=%0d d=%0h expected 2 %0h", rx_count, rx_data, c[1]);
        end
        wait_idle(20);
        pop_expect(c[1]);
        pop_expect(c[2]);
    endtask

    task automatic test_random();
        logic [7:0] tx_q [$];
        logic [7:0] rx_exp [$];
        logic       v, r;
        logic [7:0] d;
        discardRx = 1'b0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            n_checks++;
            if (tx_count !== 3'(tx_q.size()) || tx_ready !== (tx_q.size() < 4)) begin
                n_errors++; $display("FAIL rnd_tx: cyc %0d txc=%0d rdy=%0b expected %0d", cyc, tx_count, tx_ready, tx_q.size());
            end
            if (rx_valid) begin
                n_checks++;
                if (rx_exp.size() == 0 || rx_data !== rx_exp[0]) begin
                    n_errors++; $display("FAIL rnd_rx: cyc %0d rx_data=%0h expected %0h", cyc, rx_data,
                                         rx_exp.size() ? rx_exp[0] : 8'h00);
                end
            end
            if (cyc >= 400) begin
                v = 1'b0; r = 1'b1; enable = 1'b1;
            end else begin
                v = 1'($urandom % 2); r = ($urandom % 3) == 0; enable = ($urandom % 16) != 0;
            end
            d = 8'($urandom);
            if (v && tx_q.size() < 4) tx_q.push_back(d);
            if (engine_load) begin
                n_checks++;
                if (tx_q.size() == 0 || engine_data !== tx_q[0]) begin
                    n_errors++; $display("FAIL rnd_load: cyc %0d engine_data=%0h unexpected", cyc, engine_data);
                end
                if (tx_q.size() != 0) rx_exp.push_back(tx_q.pop_front());
            end
            if (r && rx_valid && rx_exp.size() != 0) void'(rx_exp.pop_front());
            tx_valid = v; tx_data = d; rx_ready = r;
            eng_len = $urandom_range(1, 6);
            @(negedge clk);
        end
        tx_valid = 1'b0; rx_ready = 1'b0;
        n_checks++;
        if (tx_q.size() != 0 || rx_exp.size() != 0 || rx_count !== 3'd0 || active !== 1'b0) begin
            n_errors++; $display("FAIL rnd_end: txq=%0d rxq=%0d rxc=%0d act=%0b expected all 0",
                                 tx_q.size(), rx_exp.size(), rx_count, active);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; flush = 1'b0; discardRx = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_full();
        test_rx_full();
        test_discard();
        test_flush();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
